// File: rtl/seven_segment_scan_controller_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   scan_state_e : scan FSM encoding (SHOW = digit lit, GUARD = dead time)
//   SEG_BLANK    : active-low segment pattern with every segment dark
//   MAX_DIGITS   : largest supported NUM_DIGITS
//   GUARD_W      : width of the guard-time counter (GUARD_CYCLES <= 255)
package seven_segment_scan_controller_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    GUARD = 1'b1
  } scan_state_e;

  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned GUARD_W    = 8;

endpackage

// File: rtl/Hexadecimal_To_Seven_Segment.sv
// Hex nibble to active-low seven-segment decoder.
//   hex_i   : 4-bit value 0..F
//   seg_n_o : active-low segments, bit 0 = a ... bit 6 = g
// Letters b and d are the lower-case shapes so they differ from 8 and 0.
module Hexadecimal_To_Seven_Segment (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = 7'h7F;
    case (hex_i)
      4'h0: seg_n_o = 7'h40;
      4'h1: seg_n_o = 7'h79;
      4'h2: seg_n_o = 7'h24;
      4'h3: seg_n_o = 7'h30;
      4'h4: seg_n_o = 7'h19;
      4'h5: seg_n_o = 7'h12;
      4'h6: seg_n_o = 7'h02;
      4'h7: seg_n_o = 7'h78;
      4'h8: seg_n_o = 7'h00;
      4'h9: seg_n_o = 7'h10;
      4'hA: seg_n_o = 7'h08;
      4'hB: seg_n_o = 7'h03;
      4'hC: seg_n_o = 7'h46;
      4'hD: seg_n_o = 7'h21;
      4'hE: seg_n_o = 7'h06;
      4'hF: seg_n_o = 7'h0E;
      default: seg_n_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Multiplexed seven-segment display scanner with double-buffered frame load.
//   clk             : system clock, rising edge
//   reset           : asynchronous, active-high
//   load_valid      : producer offers a frame (load_data / load_blank_mask)
//   load_ready      : no frame is pending; an offer is accepted this cycle
//   load_data       : nibble i drives digit i (digit 0 least significant)
//   load_blank_mask : bit i forces digit i dark
//   lz_blank_en     : leading-zero blanking, applied live
//   seg_n           : registered active-low segments, bit 0 = a
//   dig_en_n        : registered active-low digit enables, at most one low
//   frame_done      : one-cycle pulse as the scan wraps back to digit 0
// An accepted frame sits in a shadow buffer and is copied to the active
// buffer only when the scan wraps, so a frame is never torn mid-scan.
module seven_segment_scan_controller
  import seven_segment_scan_controller_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_blank_mask,
  input  logic                    lz_blank_en,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   dig_en_n,
  output logic                    frame_done
);

  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned PW = $clog2(SCAN_DIV);

  localparam logic [IW-1:0]      LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0]      LAST_PRESC = PW'(SCAN_DIV - 1);
  localparam logic [GUARD_W-1:0] LAST_GUARD =
    (GUARD_CYCLES == 0) ? '0 : GUARD_W'(GUARD_CYCLES - 1);

  scan_state_e               state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [PW-1:0]             presc_q, presc_d;
  logic [GUARD_W-1:0]        guard_q, guard_d;
  logic                      pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0]   shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0]     shadow_mask_q, shadow_mask_d;
  logic [4*NUM_DIGITS-1:0]   active_data_q, active_data_d;
  logic [NUM_DIGITS-1:0]     active_mask_q, active_mask_d;
  logic [6:0]                seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0]     dig_en_n_q, dig_en_n_d;
  logic                      frame_done_q, frame_done_d;

  logic [3:0] active_nib;
  logic       cur_mask_bit;
  logic       cur_has_value;
  logic       upper_nz;
  logic       cur_blank;
  logic [6:0] dec_seg_n;

  // Select the nibble/mask bit for the scanned digit and decide whether
  // it falls in the leading-zero region. upper_nz accumulates "some nibble
  // at or above this position is nonzero" while walking from the top down.
  always_comb begin
    active_nib    = '0;
    cur_mask_bit  = 1'b0;
    cur_has_value = 1'b0;
    upper_nz      = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      upper_nz = upper_nz | (active_data_q[4*(NUM_DIGITS-1-k) +: 4] != 4'h0);
      if (idx_q == IW'(NUM_DIGITS - 1 - k)) begin
        cur_has_value = upper_nz;
        active_nib    = active_data_q[4*(NUM_DIGITS-1-k) +: 4];
        cur_mask_bit  = active_mask_q[NUM_DIGITS-1-k];
      end
    end
    // Digit 0 always shows its value so an all-zero frame reads "0".
    cur_blank = cur_mask_bit |
                (lz_blank_en & ~cur_has_value & (idx_q != '0));
  end

  // One shared decoder serves whichever digit is currently scanned.
  Hexadecimal_To_Seven_Segment u_hex_decoder (
    .hex_i   (active_nib),
    .seg_n_o (dec_seg_n)
  );

  always_comb begin
    logic leave_show;
    logic wrap;

    state_d       = state_q;
    idx_d         = idx_q;
    presc_d       = presc_q;
    guard_d       = guard_q;
    pending_d     = pending_q;
    shadow_data_d = shadow_data_q;
    shadow_mask_d = shadow_mask_q;
    active_data_d = active_data_q;
    active_mask_d = active_mask_q;
    seg_n_d       = SEG_BLANK;
    dig_en_n_d    = '1;
    frame_done_d  = 1'b0;
    leave_show    = 1'b0;
    wrap          = 1'b0;

    case (state_q)
      SHOW: begin
        if (presc_q == LAST_PRESC) begin
          presc_d    = '0;
          leave_show = 1'b1;
          if (GUARD_CYCLES != 0) begin
            state_d = GUARD;
            guard_d = '0;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      GUARD: begin
        if (guard_q == LAST_GUARD) begin
          state_d = SHOW;
          guard_d = '0;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      default: state_d = SHOW;
    endcase

    if (leave_show) begin
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
        wrap  = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // Commit only needs pending_q and accept needs ~pending_q, so the two
    // never collide; a frame accepted on the wrap cycle waits a full scan.
    if (wrap && pending_q) begin
      active_data_d = shadow_data_q;
      active_mask_d = shadow_mask_q;
      pending_d     = 1'b0;
    end
    if (load_valid && !pending_q) begin
      shadow_data_d = load_data;
      shadow_mask_d = load_blank_mask;
      pending_d     = 1'b1;
    end

    if (state_q == SHOW && !cur_blank) begin
      seg_n_d = dec_seg_n;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (idx_q == IW'(i)) dig_en_n_d[i] = 1'b0;
      end
    end

    frame_done_d = wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SHOW;
      idx_q         <= '0;
      presc_q       <= '0;
      guard_q       <= '0;
      pending_q     <= 1'b0;
      shadow_data_q <= '0;
      shadow_mask_q <= '1;
      active_data_q <= '0;
      active_mask_q <= '1;
      seg_n_q       <= SEG_BLANK;
      dig_en_n_q    <= '1;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      presc_q       <= presc_d;
      guard_q       <= guard_d;
      pending_q     <= pending_d;
      shadow_data_q <= shadow_data_d;
      shadow_mask_q <= shadow_mask_d;
      active_data_q <= active_data_d;
      active_mask_q <= active_mask_d;
      seg_n_q       <= seg_n_d;
      dig_en_n_q    <= dig_en_n_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign load_ready = ~pending_q;
  assign seg_n      = seg_n_q;
  assign dig_en_n   = dig_en_n_q;
  assign frame_done = frame_done_q;

endmodule
